icache_refill: RTL and testbench

- Direct-mapped, read-only instruction cache with a refill FSM, placed between the PC register and the IF/ID pipeline register.
- On a hit, it returns the instruction in the same cycle, matching the timing of the combinational instruction-memory read.
- On a miss, it asserts `stall`, which the hazard logic uses to hold the PC and IF/ID. It then fetches the whole line from a slower word-wide backing memory using a req/valid handshake.

---
 rtl/cache_pkg.sv | 42 ++++
 rtl/icache_store.sv | 75 +++++++
 rtl/icache_refill.sv | 164 ++++++++++++++++
 tb/tb_icache_refill.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the instruction cache.
// Contents:
//   icache_state_t     refill FSM states (IDLE, REFILL, FILL_DONE)
//   ADDR_W / DATA_W    byte-address and instruction widths
//   DEF_LINES / DEF_WORDS and the derived DEF_* field widths
//   off_w / idx_w / tag_w  address-field widths for any LINES/WORDS
//   NOP_INSTR          value driven on instr when there is no hit
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } icache_state_t;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0;

  // Word-offset field width for a line of 'words' 32-bit words.
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Line-index field width for a cache of 'lines' lines.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever remains above index, offset and the byte bits.
  function automatic int tag_w(input int lines, input int words);
    return ADDR_W - idx_w(lines) - off_w(words) - 2;
  endfunction

  localparam int DEF_OFF_W = off_w(DEF_WORDS);
  localparam int DEF_IDX_W = idx_w(DEF_LINES);
  localparam int DEF_TAG_W = tag_w(DEF_LINES, DEF_WORDS);

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst                      clock, synchronous active-high reset (clears valids)
//   rd_index, rd_offset           combinational lookup address
//   rd_valid, rd_tag, rd_data     lookup results for that line / word
//   wr_en, wr_index, wr_offset,   synchronous single-word data write
//   wr_data
//   set_valid, set_index, set_tag mark a line valid and load its tag
//   inv_all                       clear every valid bit (wins over set_valid)
module icache_store
  import cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int OFF_W = off_w(WORDS),
  parameter int IDX_W = idx_w(LINES),
  parameter int TAG_W = tag_w(LINES, WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [OFF_W-1:0]  rd_offset,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_offset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_valid,
  input  logic [IDX_W-1:0]  set_index,
  input  logic [TAG_W-1:0]  set_tag,
  input  logic              inv_all
);

  logic              valid_vec [LINES];
  logic [TAG_W-1:0]  tag_vec   [LINES];
  logic [DATA_W-1:0] word_vec  [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic              valid_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic [DATA_W-1:0] data_reg [WORDS];

      always_ff @(posedge clk) begin
        if (rst || inv_all) begin
          valid_reg <= 1'b0;
        end else if (set_valid && set_index == IDX_W'(gi)) begin
          valid_reg <= 1'b1;
        end
      end

      // Tag and data need no reset: they are only observed through valid.
      always_ff @(posedge clk) begin
        if (set_valid && set_index == IDX_W'(gi)) begin
          tag_reg <= set_tag;
        end
        if (wr_en && wr_index == IDX_W'(gi)) begin
          data_reg[wr_offset] <= wr_data;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign tag_vec[gi]   = tag_reg;
      assign word_vec[gi]  = data_reg[rd_offset];
    end
  endgenerate

  assign rd_valid = valid_vec[rd_index];
  assign rd_tag   = tag_vec[rd_index];
  assign rd_data  = word_vec[rd_index];

endmodule

// File: rtl/icache_refill.sv
// Direct-mapped read-only instruction cache with a line-refill FSM.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pc_addr, pc_req       fetch byte address and request
//   inv                   invalidate all lines (aborts a refill in progress)
//   instr, hit            same-cycle instruction on a hit, NOP otherwise
//   stall                 hold PC and IF/ID (miss seen or refill in progress)
//   mem_req, mem_addr     word request to backing memory, held until mem_valid
//   mem_rdata, mem_valid  returned word and its completion strobe
//   miss_cnt              wrapping count of misses since reset
module icache_refill
  import cache_pkg::*;
#(
  parameter int LINES      = DEF_LINES,
  parameter int WORDS      = DEF_WORDS,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc_addr,
  input  logic                  pc_req,
  input  logic                  inv,
  output logic [DATA_W-1:0]     instr,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_valid,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

  localparam int OFF_W  = off_w(WORDS);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(LINES, WORDS);
  localparam int LINE_W = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  icache_state_t         state_reg, state_next;
  logic [LINE_W-1:0]     line_reg, line_next;       // latched {tag, index}
  logic [OFF_W-1:0]      cnt_reg, cnt_next;
  logic [MISS_CNT_W-1:0] miss_cnt_reg, miss_cnt_next;
  logic                  mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]     mem_addr_reg, mem_addr_next;

  logic [OFF_W-1:0]  pc_offset;
  logic [IDX_W-1:0]  pc_index;
  logic [TAG_W-1:0]  pc_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en, set_valid, inv_all;
  logic [OFF_W-1:0]  cnt_inc;
  logic              unused_byte_bits;

  assign pc_offset        = pc_addr[OFF_W+1:2];
  assign pc_index         = pc_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_tag           = pc_addr[ADDR_W-1:IDX_W+OFF_W+2];
  assign unused_byte_bits = ^pc_addr[1:0];
  assign cnt_inc          = cnt_reg + 1'b1;

  icache_store #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (pc_index),
    .rd_offset(pc_offset),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (line_reg[IDX_W-1:0]),
    .wr_offset(cnt_reg),
    .wr_data  (mem_rdata),
    .set_valid(set_valid),
    .set_index(line_reg[IDX_W-1:0]),
    .set_tag  (line_reg[LINE_W-1:IDX_W]),
    .inv_all  (inv_all)
  );

  // An invalidate in the same cycle suppresses the hit, since the line is
  // about to disappear.
  assign hit   = pc_req && (state_reg == IDLE) && !inv && rd_valid && (rd_tag == pc_tag);
  assign instr = hit ? rd_data : NOP_INSTR;
  assign stall = (pc_req && !hit) || (state_reg != IDLE);

  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;
  assign miss_cnt = miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      line_reg     <= '0;
      cnt_reg      <= '0;
      miss_cnt_reg <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      line_reg     <= line_next;
      cnt_reg      <= cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    line_next     = line_reg;
    cnt_next      = cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    wr_en         = 1'b0;
    set_valid     = 1'b0;
    inv_all       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (inv) begin
          inv_all = 1'b1;
        end else if (pc_req && !hit) begin
          line_next     = {pc_tag, pc_index};
          cnt_next      = '0;
          miss_cnt_next = miss_cnt_reg + 1'b1;
          mem_req_next  = 1'b1;
          mem_addr_next = {pc_tag, pc_index, {OFF_W{1'b0}}, 2'b00};
          state_next    = REFILL;
        end
      end

      REFILL: begin
        if (inv) begin
          // Abort: the outstanding response is simply never consumed.
          inv_all      = 1'b1;
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end else if (mem_valid && mem_req_reg) begin
          wr_en = 1'b1;
          if (cnt_reg == LAST_WORD) begin
            set_valid    = 1'b1;
            mem_req_next = 1'b0;
            state_next   = FILL_DONE;
          end else begin
            cnt_next      = cnt_inc;
            mem_addr_next = {line_reg, cnt_inc, 2'b00};
          end
        end
      end

      FILL_DONE: begin
        inv_all    = inv;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;

  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_addr = '0;
  logic        pc_req = 1'b0;
  logic        inv = 1'b0;
  logic [31:0] instr;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic [15:0] miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which line holds which tag, and how many misses.
  bit          m_valid [LINES];
  logic [23:0] m_tag   [LINES];
  int          m_miss;

  // Backing memory behaviour.
  int          cur_lat = 1;
  int          wait_cnt = 0;
  bit          force_valid = 1'b0;
  logic [31:0] salt;

  always #5 clk = ~clk;

  icache_refill dut (
    .clk      (clk),
    .rst      (rst),
    .pc_addr  (pc_addr),
    .pc_req   (pc_req),
    .inv      (inv),
    .instr    (instr),
    .hit      (hit),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .miss_cnt (miss_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Memory answers a held request after cur_lat cycles (latency 1 = same cycle).
  always @(negedge clk) begin
    if (force_valid) begin
      mem_valid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
    end else if (mem_req && !rst) begin
      wait_cnt++;
      if (wait_cnt >= cur_lat) begin
        mem_valid = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_valid = 1'b0;
      end
    end else begin
      mem_valid = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch transaction: hit expected from the model, or a full refill.
  task automatic fetch(input logic [31:0] a, input int lat, input bit scramble);
    int          idx = int'(a[7:4]);
    logic [23:0] tg  = a[31:8];
    logic [31:0] base = {a[31:4], 4'h0};
    bit          exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    int          exp_cyc = WORDS * lat + 2;
    int          hs = 0;
    int          cyc = 0;
    cur_lat = lat;
    @(negedge clk);
    pc_req = 1'b1; pc_addr = a; inv = 1'b0;
    #1;
    n_checks++;
    if (hit !== exp_hit) begin
      n_fail++; $display("FAIL hit_pred addr=%h hit=%b expected=%b", a, hit, exp_hit);
    end
    if (exp_hit) begin
      n_checks++;
      if (instr !== mem_word({a[31:2], 2'b00}) || stall !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL hit_data addr=%h instr=%h stall=%b mem_req=%b expected instr=%h stall=0 mem_req=0",
                 a, instr, stall, mem_req, mem_word({a[31:2], 2'b00}));
      end
      $display("fetch %h hit instr=%h", a, instr);
    end else begin
      m_miss++;
      n_checks++;
      if (stall !== 1'b1 || instr !== 32'h0) begin
        n_fail++; $display("FAIL miss_stall addr=%h stall=%b instr=%h expected stall=1 instr=0", a, stall, instr);
      end
      for (cyc = 1; cyc <= exp_cyc + 20; cyc++) begin
        @(negedge clk);
        pc_addr = (scramble && cyc < exp_cyc) ? $urandom : a;
        #1;
        if (hit) break;
        n_checks++;
        if (stall !== 1'b1 || mem_req !== (cyc <= WORDS * lat) ||
            (mem_req && mem_addr !== base + 32'(hs * 4))) begin
          n_fail++;
          $display("FAIL refill_cyc addr=%h cyc=%0d stall=%b mem_req=%b mem_addr=%h expected stall=1 mem_req=%b mem_addr=%h",
                   a, cyc, stall, mem_req, mem_addr, (cyc <= WORDS * lat), base + 32'(hs * 4));
        end
        if (mem_req && mem_valid) hs++;
      end
      n_checks++;
      if (cyc !== exp_cyc || hs !== WORDS) begin
        n_fail++; $display("FAIL penalty addr=%h cycles=%0d handshakes=%0d expected %0d and %0d", a, cyc, hs, exp_cyc, WORDS);
      end
      n_checks++;
      if (instr !== mem_word({a[31:2], 2'b00}) || miss_cnt !== 16'(m_miss)) begin
        n_fail++;
        $display("FAIL refill_data addr=%h instr=%h miss_cnt=%0d expected instr=%h miss_cnt=%0d",
                 a, instr, miss_cnt, mem_word({a[31:2], 2'b00}), m_miss);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      $display("fetch %h miss lat=%0d cycles=%0d instr=%h miss_cnt=%0d", a, lat, cyc, instr, miss_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_req = 1'b0; inv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear(); m_miss = 0;
    #1;
    n_checks++;
    if (hit !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 ||
        miss_cnt !== 16'h0 || instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset hit=%b stall=%b mem_req=%b mem_addr=%h miss_cnt=%0d instr=%h expected all zero",
               hit, stall, mem_req, mem_addr, miss_cnt, instr);
    end
    $display("reset done");
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0040, 1, 1'b0);
  endtask

  task automatic test_hits();
    fetch(32'h0000_0044, 1, 1'b0);
    fetch(32'h0000_0048, 1, 1'b0);
    fetch(32'h0000_004C, 1, 1'b0);
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0140, 1, 1'b0);
    fetch(32'h0000_014C, 1, 1'b0);
    fetch(32'h0000_0040, 1, 1'b0);
    n_checks++;
    if (miss_cnt !== 16'd3) begin
      n_fail++; $display("FAIL conflict_cnt miss_cnt=%0d expected 3", miss_cnt);
    end
  endtask

  task automatic test_inv_idle();
    @(negedge clk);
    pc_req = 1'b1; pc_addr = 32'h0000_0040; inv = 1'b1;
    #1;
    n_checks++;
    if (hit !== 1'b0 || instr !== 32'h0) begin
      n_fail++; $display("FAIL inv_idle_hit hit=%b instr=%h expected 0 and 0", hit, instr);
    end
    model_clear();
    @(negedge clk);
    pc_req = 1'b0; inv = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || miss_cnt !== 16'(m_miss)) begin
      n_fail++;
      $display("FAIL inv_idle_norefill mem_req=%b stall=%b miss_cnt=%0d expected 0 0 %0d", mem_req, stall, miss_cnt, m_miss);
    end
    $display("invalidate in idle");
    fetch(32'h0000_0044, 1, 1'b0);
  endtask

  task automatic test_inv_refill();
    int n = 0;
    cur_lat = 3;
    @(negedge clk);
    pc_req = 1'b1; pc_addr = 32'h0000_0080;
    m_miss++;
    #1;
    while (!(mem_req && mem_addr == 32'h0000_0084) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    n_checks++;
    if (n >= 40) begin
      n_fail++; $display("FAIL inv_refill_wait mem_addr=%h expected 00000084 outstanding", mem_addr);
    end
    inv = 1'b1; force_valid = 1'b1;
    @(negedge clk);
    inv = 1'b0; pc_req = 1'b0;
    #1;
    force_valid = 1'b0;
    model_clear();
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL inv_refill_abort mem_req=%b stall=%b expected 0 0", mem_req, stall);
    end
    @(negedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || miss_cnt !== 16'(m_miss)) begin
      n_fail++;
      $display("FAIL inv_refill_late mem_req=%b stall=%b miss_cnt=%0d expected 0 0 %0d", mem_req, stall, miss_cnt, m_miss);
    end
    $display("invalidate during refill of 00000080");
    fetch(32'h0000_0080, 1, 1'b0);
  endtask

  task automatic test_stretched();
    fetch(32'h0000_0208, 5, 1'b1);
    fetch(32'h0000_0200, 5, 1'b0);
    fetch(32'h0000_020C, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    cur_lat = 2;
    @(negedge clk);
    pc_req = 1'b1; pc_addr = 32'h0000_0300;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pc_req = 1'b0;
    model_clear(); m_miss = 0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || miss_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid mem_req=%b stall=%b miss_cnt=%0d expected 0 0 0", mem_req, stall, miss_cnt);
    end
    $display("reset during refill");
    fetch(32'h0000_0080, 1, 1'b0);
    fetch(32'h0000_0200, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      fetch(a, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    salt = $urandom;
    m_miss = 0;
    model_clear();
    for (int i = 0; i < LINES; i++) m_tag[i] = '0;
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_inv_idle();
    test_inv_refill();
    test_stretched();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
